axi4_burst_master: RTL



---
 rtl/axi4_burst_master.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_burst_master
//  Purpose  : Command-driven AXI4 master. Issues one INCR burst (1-256 beats)
//             per command. Write data and read data stream through the master
//             with no added latency. Each command returns a completion status.
//  Options  : AXI_MASTER_STATS_EN adds saturating completion counters
//             (stat_wr_cnt, stat_rd_cnt, stat_err_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  // write-data stream
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read-data stream
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic                  busy,
  // AW channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // W channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  // B channel
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // AR channel
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // R channel
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
`ifdef AXI_MASTER_STATS_EN
  ,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  localparam int              C_BYTES = DATA_WIDTH / 8;
  localparam int              C_SIZE  = $clog2(C_BYTES);
  localparam logic [2:0]      C_AXSIZE = 3'(C_SIZE);
  // wide enough for address + 256 beats of bytes without wrapping
  localparam int              C_EW    = ADDR_WIDTH + C_SIZE + 10;
  localparam logic [C_EW-1:0] C_SPAN  = C_EW'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ADDR_WIDTH'(C_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nx;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [7:0]              r_beat;
  logic [1:0]              r_resp;
  logic                    r_rlast_err;

  logic [C_EW-1:0]         w_end_addr;
  logic                    w_cmd_bad;
  logic                    w_cmd_fire;
  logic                    w_last_beat;
  logic                    w_run;

  assign w_run       = !ARESET;
  assign w_end_addr  = C_EW'(cmd_addr) + ((C_EW'(cmd_len) + C_EW'(1)) << C_SIZE);
  assign w_cmd_bad   = (|(cmd_addr & C_ALIGN_MASK)) || (w_end_addr > C_SPAN);
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_last_beat = (r_beat == r_len);

  // address channels come straight from registers
  assign AWADDR    = r_addr;
  assign AWLEN     = r_len;
  assign AWSIZE    = C_AXSIZE;
  assign ARADDR    = r_addr;
  assign ARLEN     = r_len;
  assign ARSIZE    = C_AXSIZE;
  assign WDATA     = wr_data;
  assign rd_data   = RDATA;
  assign done_resp = r_rlast_err ? 2'b10 : r_resp;
  assign busy      = (r_state != S_IDLE);

  // state register
  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // next-state and handshake steering; every valid/ready is masked during reset
  always_comb begin
    w_state_nx = r_state;
    cmd_ready  = 1'b0;
    AWVALID    = 1'b0;
    WVALID     = 1'b0;
    WLAST      = 1'b0;
    wr_ready   = 1'b0;
    BREADY     = 1'b0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    done_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = w_run;
        if (cmd_valid && w_run) begin
          if (w_cmd_bad)      w_state_nx = S_DONE;
          else if (cmd_write) w_state_nx = S_AW;
          else                w_state_nx = S_AR;
        end
      end
      S_AW: begin
        AWVALID = w_run;
        if (w_run && AWREADY) w_state_nx = S_W;
      end
      S_W: begin
        WVALID   = wr_valid && w_run;
        wr_ready = WREADY && w_run;
        WLAST    = w_last_beat && w_run;
        if (WVALID && WREADY && WLAST) w_state_nx = S_B;
      end
      S_B: begin
        BREADY = w_run;
        if (BVALID && BREADY) w_state_nx = S_DONE;
      end
      S_AR: begin
        ARVALID = w_run;
        if (w_run && ARREADY) w_state_nx = S_R;
      end
      S_R: begin
        RREADY   = rd_ready && w_run;
        rd_valid = RVALID && w_run;
        rd_last  = RLAST && w_run;
        if (RVALID && RREADY && w_last_beat) w_state_nx = S_DONE;
      end
      S_DONE: begin
        done_valid = w_run;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // command capture, beat counting and response accumulation
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_resp      <= '0;
      r_rlast_err <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_addr      <= cmd_addr;
        r_len       <= cmd_len;
        r_beat      <= '0;
        r_rlast_err <= 1'b0;
        r_resp      <= w_cmd_bad ? 2'b10 : 2'b00;
      end
      if (r_state == S_W && WVALID && WREADY) begin
        r_beat <= r_beat + 8'd1;
      end
      if (r_state == S_B && BVALID && BREADY) begin
        r_resp <= BRESP;
      end
      if (r_state == S_R && RVALID && RREADY) begin
        r_beat <= r_beat + 8'd1;
        // a slave whose RLAST disagrees with the requested length is flagged
        if (RLAST != w_last_beat) r_rlast_err <= 1'b1;
        if (RRESP > r_resp)       r_resp      <= RRESP;
      end
    end
  end

`ifdef AXI_MASTER_STATS_EN
  logic r_is_wr;

  // remember the direction of the command in flight for the counters
  always_ff @(posedge ACLK) begin
    if (ARESET)          r_is_wr <= 1'b0;
    else if (w_cmd_fire) r_is_wr <= cmd_write;
  end

  // saturating completion counters
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (done_valid) begin
      if (r_is_wr && stat_wr_cnt != 16'hFFFF)   stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (!r_is_wr && stat_rd_cnt != 16'hFFFF)  stat_rd_cnt <= stat_rd_cnt + 16'd1;
      if (done_resp != 2'b00 && stat_err_cnt != 16'hFFFF)
        stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
